// File: rtl/alu_pkg.sv
// Shared definitions for alu_seq_unit: op encodings, FSM states, multiply
// iteration count and the single-edge ALU helper functions.
package alu_pkg;

  localparam int ALU_W    = 8;
  localparam int MUL_ITER = 8;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_AND = 2'b11
  } alu_op_e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MUL_RUN = 1'b1
  } alu_state_e;

  function automatic logic [ALU_W-1:0] alu_result(input alu_op_e op,
                                                   input logic [ALU_W-1:0] a,
                                                   input logic [ALU_W-1:0] b);
    case (op)
      OP_ADD:  alu_result = a + b;
      OP_SUB:  alu_result = a + ~b + ALU_W'(1);
      OP_AND:  alu_result = a & b;
      default: alu_result = '0;
    endcase
  endfunction

  // SUB carry is the inverted borrow, i.e. set when no borrow occurs.
  function automatic logic alu_carry(input alu_op_e op,
                                     input logic [ALU_W-1:0] a,
                                     input logic [ALU_W-1:0] b);
    case (op)
      OP_ADD:  alu_carry = (a + b) < a;
      OP_SUB:  alu_carry = (a >= b);
      default: alu_carry = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_mul_serial.sv
// Shift-add multiplier: operands captured on start, one iteration per edge for MUL_ITER edges.
// done/product are combinational and valid on the edge that retires the final iteration.
module alu_mul_serial
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  output logic                busy,
  output logic                done,
  output logic [2*DATA_W-1:0] product
);

  localparam int CNT_W = $clog2(MUL_ITER);

  logic                busy_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   mcand_q;
  logic [2*DATA_W-1:0] prod_q;
  logic [2*DATA_W-1:0] prod_d;
  logic [DATA_W:0]     psum;

  // Upper half accumulates the multiplicand; lower half holds the remaining multiplier bits.
  always_comb begin
    psum   = {1'b0, prod_q[2*DATA_W-1:DATA_W]}
           + (prod_q[0] ? {1'b0, mcand_q} : {(DATA_W+1){1'b0}});
    prod_d = {psum, prod_q[DATA_W-1:1]};
  end

  assign done    = busy_q && (cnt_q == CNT_W'(MUL_ITER - 1));
  assign busy    = busy_q;
  assign product = prod_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
    end else if (busy_q) begin
      prod_q <= prod_d;
      cnt_q  <= cnt_q + CNT_W'(1);
      if (done) begin
        busy_q <= 1'b0;
      end
    end else if (start) begin
      prod_q  <= {{DATA_W{1'b0}}, b};
      mcand_q <= a;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end
  end

endmodule

// File: rtl/alu_seq_unit.sv
// Sequential ALU: ADD/SUB/AND complete on the accepting edge, MUL runs serially for MUL_ITER edges.
// Define ALU_FLAGS_EN to build the {carry, zero, negative} flag register; otherwise flags read 0.
module alu_seq_unit
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] regA,
  input  logic [DATA_W-1:0] regB,
  input  logic [1:0]        op,
  input  logic              op_valid,
  input  logic              enable_output,
  input  logic              enable_output_hi,
  inout  wire  [DATA_W-1:0] bus,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] mul_hi,
  output logic [2:0]        flags
);

  alu_state_e          state_q;
  logic                busy_q;
  logic                done_q;
  logic [DATA_W-1:0]   result_q;
  logic [DATA_W-1:0]   mul_hi_q;
  alu_op_e             op_e;
  logic [DATA_W-1:0]   alu_res;
  logic                mul_start;
  logic                mul_busy;
  logic                mul_done;
  logic [2*DATA_W-1:0] mul_prod;

  assign op_e      = alu_op_e'(op);
  assign alu_res   = alu_result(op_e, regA, regB);
  assign mul_start = op_valid && (state_q == ST_IDLE) && (op_e == OP_MUL);

`ifdef ALU_FLAGS_EN
  logic [2:0] flags_q;
  logic       alu_c;
  assign alu_c = alu_carry(op_e, regA, regB);
  assign flags = flags_q;
`else
  assign flags = 3'b000;
`endif

  alu_mul_serial #(
    .DATA_W (DATA_W)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (regA),
    .b       (regB),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      mul_hi_q <= '0;
`ifdef ALU_FLAGS_EN
      flags_q  <= 3'b000;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (op_valid) begin
            if (op_e == OP_MUL) begin
              state_q <= ST_MUL_RUN;
              busy_q  <= 1'b1;
            end else begin
              result_q <= alu_res;
              done_q   <= 1'b1;
`ifdef ALU_FLAGS_EN
              flags_q  <= {alu_c, alu_res == '0, alu_res[DATA_W-1]};
`endif
            end
          end
        end
        // Requests arriving here are dropped; result/mul_hi keep the last completed values.
        ST_MUL_RUN: begin
          if (mul_busy && mul_done) begin
            result_q <= mul_prod[DATA_W-1:0];
            mul_hi_q <= mul_prod[2*DATA_W-1:DATA_W];
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
`ifdef ALU_FLAGS_EN
            flags_q  <= {|mul_prod[2*DATA_W-1:DATA_W],
                         mul_prod[DATA_W-1:0] == '0,
                         mul_prod[DATA_W-1]};
`endif
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign mul_hi = mul_hi_q;

  assign bus = enable_output    ? result_q :
               enable_output_hi ? mul_hi_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed bench for alu_seq_unit: reference model plus per-cycle compare and literal spot checks.
module tb_alu_seq_unit;

`ifdef ALU_FLAGS_EN
  localparam bit FLAGS_ON = 1'b1;
`else
  localparam bit FLAGS_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] regA, regB;
  logic [1:0] op;
  logic       op_valid, enable_output, enable_output_hi;
  wire  [7:0] bus;
  logic       busy, done;
  logic [7:0] result, mul_hi;
  logic [2:0] flags;
  logic       tb_drv;

  int total = 0;
  int bad   = 0;

  assign bus = tb_drv ? 8'h5A : 8'hzz;

  always #5 clk = ~clk;

  alu_seq_unit #(.DATA_W(8)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .regA             (regA),
    .regB             (regB),
    .op               (op),
    .op_valid         (op_valid),
    .enable_output    (enable_output),
    .enable_output_hi (enable_output_hi),
    .bus              (bus),
    .busy             (busy),
    .done             (done),
    .result           (result),
    .mul_hi           (mul_hi),
    .flags            (flags)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: countdown of remaining multiply edges, integer arithmetic for results.
  logic [7:0]  m_res, m_hi;
  logic        m_busy, m_done;
  logic [2:0]  m_flags;
  int          m_left;
  logic [15:0] m_prod;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    int         s;
    logic       c;
    logic [7:0] r;
    chk_en <= 1'b1;
    if (!rst_n) begin
      m_res <= 8'h00; m_hi <= 8'h00; m_busy <= 1'b0; m_done <= 1'b0;
      m_flags <= 3'b000; m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_res   <= m_prod[7:0];
          m_hi    <= m_prod[15:8];
          m_busy  <= 1'b0;
          m_done  <= 1'b1;
          m_flags <= {m_prod > 16'd255, m_prod[7:0] == 8'h00, m_prod[7]};
        end
      end else if (op_valid) begin
        if (op == 2'b10) begin
          m_prod <= 16'(int'(regA) * int'(regB));
          m_left <= 8;
          m_busy <= 1'b1;
        end else begin
          c = 1'b0;
          r = 8'h00;
          case (op)
            2'b00: begin s = int'(regA) + int'(regB); r = 8'(s % 256); c = (s > 255); end
            2'b01: begin s = int'(regA) - int'(regB); r = 8'((s + 256) % 256); c = (regA >= regB); end
            default: r = regA & regB;
          endcase
          m_res   <= r;
          m_done  <= 1'b1;
          m_flags <= {c, r == 8'h00, r[7]};
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_busy",   {15'd0, busy}, {15'd0, m_busy});
      check("cyc_done",   {15'd0, done}, {15'd0, m_done});
      check("cyc_result", {8'd0, result}, {8'd0, m_res});
      check("cyc_mul_hi", {8'd0, mul_hi}, {8'd0, m_hi});
      check("cyc_flags",  {13'd0, flags}, {13'd0, (FLAGS_ON ? m_flags : 3'b000)});
    end
  end

  task automatic issue(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    regA = a; regB = b; op = o; op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  function automatic logic [15:0] fl(input logic [2:0] f);
    return {13'd0, (FLAGS_ON ? f : 3'b000)};
  endfunction

  initial begin
    int cnt;
    int dn;
    rst_n = 1'b0; op_valid = 1'b0; op = 2'b00; regA = 8'h00; regB = 8'h00;
    enable_output = 1'b0; enable_output_hi = 1'b0; tb_drv = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_result", {8'd0, result}, 16'h0000);
    check("rst_mul_hi", {8'd0, mul_hi}, 16'h0000);
    check("rst_busy",   {15'd0, busy}, 16'h0000);
    check("rst_done",   {15'd0, done}, 16'h0000);
    check("rst_flags",  {13'd0, flags}, 16'h0000);
    enable_output = 1'b1; #1;
    check("rst_bus", {8'd0, bus}, 16'h0000);
    enable_output = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    issue(2'b00, 8'h7F, 8'h01);
    check("add_done",  {15'd0, done}, 16'h0001);
    check("add_res",   {8'd0, result}, 16'h0080);
    check("add_flags", {13'd0, flags}, fl(3'b001));
    @(negedge clk);
    check("add_done_clr", {15'd0, done}, 16'h0000);

    issue(2'b01, 8'h05, 8'h05);
    check("sub0_res",   {8'd0, result}, 16'h0000);
    check("sub0_flags", {13'd0, flags}, fl(3'b110));
    issue(2'b01, 8'h03, 8'h05);
    check("subn_res",   {8'd0, result}, 16'h00FE);
    check("subn_flags", {13'd0, flags}, fl(3'b001));

    @(negedge clk);
    regA = 8'h01; regB = 8'h02; op = 2'b00; op_valid = 1'b1;
    @(negedge clk);
    check("b2b_first", {8'd0, result}, 16'h0003);
    regA = 8'hFF; regB = 8'h55; op = 2'b11;
    @(negedge clk);
    op_valid = 1'b0;
    check("b2b_and",  {8'd0, result}, 16'h0055);
    check("b2b_done", {15'd0, done}, 16'h0001);

    issue(2'b10, 8'h10, 8'h10);
    cnt = 0;
    while (busy && cnt < 20) begin cnt++; @(negedge clk); end
    check("mul1_busy_cycles", 16'(cnt), 16'd8);
    check("mul1_done",  {15'd0, done}, 16'h0001);
    check("mul1_lo",    {8'd0, result}, 16'h0000);
    check("mul1_hi",    {8'd0, mul_hi}, 16'h0001);
    check("mul1_flags", {13'd0, flags}, fl(3'b110));

    issue(2'b10, 8'h0F, 8'h11);
    repeat (9) @(negedge clk);
    check("mul2_prod",  {mul_hi, result}, 16'h00FF);
    check("mul2_flags", {13'd0, flags}, fl(3'b001));

    issue(2'b10, 8'h0D, 8'h0B);
    repeat (2) @(negedge clk);
    issue(2'b00, 8'h01, 8'h01);
    dn = 0;
    repeat (12) begin if (done) dn++; @(negedge clk); end
    check("midmul_done_count", 16'(dn), 16'd1);
    check("midmul_prod", {mul_hi, result}, 16'h008F);

    issue(2'b10, 8'hFF, 8'hFF);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy",   {15'd0, busy}, 16'h0000);
    check("abort_done",   {15'd0, done}, 16'h0000);
    check("abort_result", {8'd0, result}, 16'h0000);
    rst_n = 1'b1;
    dn = 0;
    repeat (12) begin if (done) dn++; @(negedge clk); end
    check("abort_no_late_done", 16'(dn), 16'd0);

    issue(2'b10, 8'hAB, 8'hCD);
    repeat (9) @(negedge clk);
    check("mul3_prod", {mul_hi, result}, 16'h88EF);
    issue(2'b00, 8'h12, 8'h22);
    check("alu_keeps_hi", {mul_hi, result}, 16'h8834);
    enable_output = 1'b1; #1;
    check("bus_result", {8'd0, bus}, 16'h0034);
    enable_output_hi = 1'b1; #1;
    check("bus_both", {8'd0, bus}, 16'h0034);
    enable_output = 1'b0; #1;
    check("bus_hi", {8'd0, bus}, 16'h0088);
    enable_output_hi = 1'b0; tb_drv = 1'b1; #1;
    check("bus_hiz", {8'd0, bus}, 16'h005A);
    tb_drv = 1'b0;

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_seq_unit.md
ALU_SEQ_UNIT -- requirements
Module: alu_seq_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 8, datapath width; only 8 is required to be supported.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port regA  input  8  accumulator operand.
REQ-005 SHALL have port regB  input  8  B-register operand.
REQ-006 SHALL have port op  input  2  operation: 00 ADD, 01 SUB, 10 MUL, 11 AND.
REQ-007 SHALL have port op_valid  input  1  request pulse; sampled on a rising edge.
REQ-008 SHALL have port enable_output  input  1  drive result onto bus when 1.
REQ-009 SHALL have port enable_output_hi  input  1  drive mul_hi onto bus when 1.
REQ-010 SHALL have port bus  inout  8  shared tri-state system bus.
REQ-011 SHALL have port busy, done  output  1 each  MUL in progress; one-cycle completion pulse.
REQ-012 SHALL have port result, mul_hi  output  8 each  registered low result; MUL high byte.
REQ-013 SHALL have port flags  output  3  {carry, zero, negative}.

Function
REQ-014 SHALL implement FSM states IDLE and MUL_RUN; reset enters IDLE.
REQ-015 SHALL accept op_valid only in IDLE; op_valid in MUL_RUN is ignored with no state change.
REQ-016 SHALL, for ADD/SUB/AND accepted at edge N, write result at edge N and hold done=1 for exactly the cycle after edge N.
REQ-017 SHALL compute ADD as regA+regB mod 256, carry = bit 8.
REQ-018 SHALL compute SUB as regA+~regB+1 mod 256, carry = bit 8 (1 = no borrow).
REQ-019 SHALL compute AND bitwise, carry = 0.
REQ-020 SHALL, for MUL accepted at edge N, capture operands, enter MUL_RUN with busy=1 from the cycle after edge N, and iterate shift-add once per edge.
REQ-021 SHALL write the 16-bit product {mul_hi, result} at edge N+8, return to IDLE, deassert busy, and assert done for that one following cycle.
REQ-022 SHALL set MUL carry = (mul_hi != 0).
REQ-023 SHALL leave result and mul_hi unchanged during MUL_RUN; they show the last completed values.
REQ-024 SHALL leave mul_hi unchanged by ADD/SUB/AND.
REQ-025 SHALL drive bus = result when enable_output=1, else mul_hi when enable_output_hi=1, else high-Z; enable_output wins if both are 1.
REQ-026 SHALL accept a new op_valid in the same cycle that done is high.

Reset
REQ-027 SHALL, on rst_n=0 at an edge, clear result, mul_hi, flags, busy, and done, enter IDLE, and abort any multiply with no done.
REQ-028 SHALL keep the bus high-Z during reset unless an enable is asserted, in which case it drives the reset value 0x00.

Configuration
REQ-029 SHALL, with ALU_FLAGS_EN defined, update flags at the edge writing result: zero=(result==0), negative=result[7], carry per REQ-017..022.
REQ-030 SHALL, without ALU_FLAGS_EN, tie flags to 3'b000 and contain no flag registers.

Structure
REQ-031 SHALL place op encodings, the FSM state enum, and MUL_ITER=8 in the shared package alu_pkg.
REQ-032 SHALL implement the multiplier as sub-module alu_mul_serial, with start/operands in and busy/done/product out.

Verification
REQ-033 ADD 0x7F+0x01 -> result 0x80, flags C0 Z0 N1, done one cycle after the accepting edge.
REQ-034 SUB 0x05-0x05 -> result 0x00, flags C1 Z1 N0; SUB 0x03-0x05 -> 0xFE, C0 N1.
REQ-035 MUL 0x10*0x10 -> busy for 8 cycles, then result 0x00, mul_hi 0x01, C1 Z1; MUL 0x0F*0x11 -> 0xFF/0x00, C0 N1.
REQ-036 op_valid ADD issued mid-MUL -> ignored; the product is unchanged and exactly one done pulse occurs.
REQ-037 rst_n=0 at MUL iteration 4 -> next cycle busy=0, done=0, result=0, and no late done follows.
REQ-038 Bus checks: enable_output=1 -> bus=result; enable_output_hi only -> bus=mul_hi; both 0 -> bus=Z; compile both with and without ALU_FLAGS_EN.
